fft_bitrev_unscramble_buffer: RTL and testbench
===============================================

Name: fft_bitrev_unscramble_buffer

Overview:
Streaming reorder buffer for the FFT datapath. It undoes bit-reversed ordering: samples arrive one per handshake in bit-reversed index order and leave in natural index order. It sits after the FFT butterfly stages and before the magnitude/display logic. Ping-pong storage (two banks of SAMPLES entries) lets one frame be written while the previous frame is read, giving full throughput.

Parameters:
SAMPLES, 8, frame length; must be a power of 2 and at least 2.
WIDTH, 3, sample data width in bits.
ADDR_W, $clog2(SAMPLES), derived localparam; not user-overridable.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset; synchronous, active-low.
in_valid  input  1  input sample present.
in_ready  output  1  buffer can accept a sample.
in_data  input  WIDTH  input sample, bit-reversed arrival order.
out_valid  output  1  output sample present.
out_ready  input  1  downstream accepts the sample.
out_data  output  WIDTH  output sample, natural order.
out_last  output  1  marks the final sample (index SAMPLES-1) of the frame.

Behaviour:
- Reset (rst_n low at a clock edge):
  - wcnt, rcnt, wbank and rbank clear to 0.
  - Both bank-full flags clear.
  - Memory contents are not reset.
  - in_ready=0 while rst_n is low.
  - out_valid=0, out_data=0, out_last=0.
- Reset mid-frame discards any partial input frame and any unread frame. No output follows until a fresh, complete frame has been written.
- Input accept: occurs when in_valid && in_ready.
  - On accept, mem[wbank][bitrev(wcnt)] <= in_data, then wcnt increments.
  - When wcnt==SAMPLES-1 is accepted: wcnt wraps to 0, full[wbank] sets and wbank toggles.
- in_ready = rst_n && !full[wbank]. This is combinational from flops, with no dependency on in_valid.
- Output:
  - out_valid = full[rbank].
  - out_data = mem[rbank][rcnt] when out_valid is high, else 0.
  - out_last = out_valid && (rcnt==SAMPLES-1).
- Output accept: occurs when out_valid && out_ready, and rcnt increments.
  - On accept with out_last=1: rcnt wraps to 0, full[rbank] clears and rbank toggles.
- Stall: while out_valid && !out_ready, out_data, out_last and rcnt stay stable.
- Latency: the last sample of a frame is accepted at edge N. out_valid=1 with natural index 0 is presented in the cycle after edge N.
- Simultaneous set/clear:
  - Setting full on one bank and clearing full on the other in the same cycle is legal. Both updates take effect.
  - The same bank cannot be both set and cleared in one cycle, because wbank!=rbank whenever both banks are full.
- Both banks full: in_ready=0 until the reader frees a bank. On the cycle after the freeing edge, in_ready=1.
- Throughput: with out_ready held at 1, continuous input at 1 sample/cycle is sustained indefinitely and in_ready never drops.
- Address arithmetic: bitrev reverses the ADDR_W bits of wcnt. Counters are ADDR_W bits wide and wrap naturally.
- Frames carry no framing input. Every SAMPLES consecutive accepts form one frame.

Decomposition:
- Package fft_pkg holds:
  - the bitrev function, parameterised by width;
  - a shared constant for default SAMPLES/WIDTH;
  - a bank-index typedef.
- One natural sub-module: fft_bitrev_index. It is combinational, maps an ADDR_W-bit index to its bit-reversed value, and is reused by the FFT scramble path.
- Storage is an inferred flop array [2][SAMPLES][WIDTH].

Test Plan:
- Single frame, SAMPLES=8, in_data=k on the k-th accept (k=0..7), out_ready=1 -> out_data sequence 0,4,2,6,1,5,3,7. out_last=1 only on the 8th output. out_valid rises exactly one cycle after the 8th accept.
- Round trip: feed 0,4,2,6,1,5,3,7 -> outputs 0..7 in order.
- Backpressure: out_ready=0 for 5 cycles mid-frame at output index 3 -> out_data=6 held stable and rcnt frozen. Output resumes with 1,5,3,7 once out_ready=1.
- Both banks full: out_ready=0, 17 input samples offered back-to-back -> in_ready drops after the 16th accept and the 17th is not accepted. in_ready returns one cycle after the 8th output accept of frame 0.
- Full throughput: out_ready=1, 3 frames (24 samples) on consecutive cycles -> in_ready=1 on every cycle. 24 outputs, each frame bit-reverse-unscrambled, with no bubbles after the first out_valid.
- Reset mid-frame: rst_n low for 1 cycle after 5 accepts, then one full frame with in_data=8+k -> outputs 8,12,10,14,9,13,11,15. No stale data appears, and out_valid/out_data=0 during reset.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
//   bitrev()              : reverses the low w bits of x (w <= BITREV_MAX_W)
//   FFT_DEFAULT_SAMPLES   : default frame length
//   FFT_DEFAULT_WIDTH     : default sample width
//   bank_t                : ping-pong bank index
package fft_pkg;

  localparam int unsigned FFT_DEFAULT_SAMPLES = 8;
  localparam int unsigned FFT_DEFAULT_WIDTH   = 3;

  localparam int unsigned BITREV_MAX_W = 16;
  localparam int unsigned BITREV_IDX_W = $clog2(BITREV_MAX_W);

  typedef logic bank_t;

  // Bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                     input int unsigned              w);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) r[BITREV_IDX_W'(i)] = x[BITREV_IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Combinational bit-reversal of an ADDR_W-bit index.
//   idx     : natural-order index
//   idx_rev : idx with its ADDR_W bits reversed
module fft_bitrev_index
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] idx_rev
);

  assign idx_rev = ADDR_W'(bitrev(BITREV_MAX_W'(idx), ADDR_W));

endmodule

// File: rtl/fft_bitrev_unscramble_buffer.sv
// Ping-pong reorder buffer: accepts one frame in bit-reversed order while
// presenting the previous frame in natural order.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data in bit-reversed order
//   out_valid/out_ready : output handshake, out_data in natural order
//   out_last            : marks natural index SAMPLES-1 of each frame
module fft_bitrev_unscramble_buffer
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLES = FFT_DEFAULT_SAMPLES,
  parameter int unsigned WIDTH   = FFT_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned ADDR_W = $clog2(SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLES - 1);

  logic [WIDTH-1:0]  mem [2][SAMPLES];
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] waddr;
  bank_t             wbank;
  bank_t             rbank;
  logic [1:0]        full;
  logic              in_fire;
  logic              out_fire;

  // Scatter writes to the bit-reversed slot so reads can walk linearly.
  fft_bitrev_index #(
    .ADDR_W (ADDR_W)
  ) u_wr_rev (
    .idx     (wcnt),
    .idx_rev (waddr)
  );

  // Handshake and output decode, all from flops (in_ready also from rst_n).
  always_comb begin
    in_ready  = rst_n && !full[wbank];
    out_valid = full[rbank];
    out_data  = out_valid ? mem[rbank][rcnt] : '0;
    out_last  = out_valid && (rcnt == LAST_IDX);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // Sample storage; not reset.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wbank][waddr] <= in_data;
  end

  // Counters, bank pointers and full flags. Writer and reader only ever
  // touch different banks when both fire on a frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt  <= '0;
      rcnt  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full  <= '0;
    end else begin
      if (in_fire) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST_IDX) begin
          full[wbank] <= 1'b1;
          wbank       <= ~wbank;
        end
      end
      if (out_fire) begin
        rcnt <= rcnt + 1'b1;
        if (out_last) begin
          full[rbank] <= 1'b0;
          rbank       <= ~rbank;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_unscramble_buffer.sv
module tb_fft_bitrev_unscramble_buffer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;

  int errors;
  int checks;

  // Natural index r of an 8-sample frame holds the sample accepted r-bit-reversed.
  logic [31:0] rev8;

  fft_bitrev_unscramble_buffer #(
    .SAMPLES (8),
    .WIDTH   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer 8 samples back-to-back; nibble k of data is the k-th sample.
  task automatic send_frame(input string tag, input logic [31:0] data);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = data[4*k +: 4];
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".no_early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Drain 8 outputs with out_ready high; nibble r of exp is natural index r.
  task automatic recv_frame(input string tag, input logic [31:0] exp);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".out_data"}, 32'(out_data), 32'(exp[4*r +: 4]));
      chk({tag, ".out_last"}, 32'(out_last), (r == 7) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rev8      = 32'h73516240;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    chk("rel.out_valid", 32'(out_valid), 32'd0);

    // Single frame 0..7: natural order gives 0,4,2,6,1,5,3,7; valid right after 8th accept.
    out_ready = 1'b1;
    send_frame("single", 32'h76543210);
    recv_frame("single", 32'h73516240);
    chk("single.drained", 32'(out_valid), 32'd0);

    // Round trip: bit-reversed feed comes back as 0..7.
    send_frame("round", 32'h73516240);
    recv_frame("round", 32'h76543210);
    chk("round.drained", 32'(out_valid), 32'd0);

    // Backpressure at natural index 3.
    send_frame("bp", 32'h76543210);
    for (int r = 0; r < 3; r++) begin
      chk("bp.pre_data", 32'(out_data), 32'(rev8[4*r +: 4]));
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_data", 32'(out_data), 32'd6);
      chk("bp.hold_last", 32'(out_last), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int r = 3; r < 8; r++) begin
      chk("bp.resume_data", 32'(out_data), 32'(rev8[4*r +: 4]));
      chk("bp.resume_last", 32'(out_last), (r == 7) ? 32'd1 : 32'd0);
      tick();
    end
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Both banks full: 17 offered with no reader; 16 taken.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      chk("full.in_ready", 32'(in_ready), (i < 16) ? 32'd1 : 32'd0);
      tick();
    end
    chk("full.still_blocked", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      chk("full.f0_data", 32'(out_data), 32'(rev8[4*r +: 4]));
      chk("full.f0_blocked", 32'(in_ready), 32'd0);
      tick();
    end
    chk("full.in_ready_back", 32'(in_ready), 32'd1);
    recv_frame("full.f1", 32'hFBD9EAC8);
    chk("full.drained", 32'(out_valid), 32'd0);

    // Full throughput: 3 frames on consecutive cycles, frame f sample k = k+4f.
    out_ready = 1'b1;
    for (int t = 0; t < 34; t++) begin
      if (t < 24) begin
        in_valid = 1'b1;
        in_data  = 4'((t % 8) + 4 * (t / 8));
        chk("tput.in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (t >= 8 && t < 32) begin
        chk("tput.out_valid", 32'(out_valid), 32'd1);
        chk("tput.out_data", 32'(out_data),
            32'(4'(rev8[4*((t-8)%8) +: 4] + 4'(4 * ((t-8)/8)))));
        chk("tput.out_last", 32'(out_last), (((t-8)%8) == 7) ? 32'd1 : 32'd0);
      end else begin
        chk("tput.idle_valid", 32'(out_valid), 32'd0);
      end
      tick();
    end

    // Reset mid-frame after 5 accepts; partial frame must vanish.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid.in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    chk("mid.out_valid_rst", 32'(out_valid), 32'd0);
    chk("mid.out_data_rst", 32'(out_data), 32'd0);
    chk("mid.out_last_rst", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid.in_ready_rel", 32'(in_ready), 32'd1);
    send_frame("mid", 32'hFEDCBA98);
    recv_frame("mid", 32'hFBD9EAC8);
    chk("mid.drained", 32'(out_valid), 32'd0);
    tick();
    chk("mid.no_stale", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
